// File: rtl/dpfpm_scheduler_pkg.sv
// rtl/dpfpm_scheduler_pkg.sv - shared constants and state encoding for the FP multiplier scheduler
// Purpose: datapath width, FSM state encoding and IEEE-754 double constants.
// Ports: none (package).
package dpfpm_scheduler_pkg;

  localparam int DP_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [DP_W-1:0] DP_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [DP_W-1:0] DP_INF  = 64'h7FF0_0000_0000_0000;
  localparam logic [DP_W-1:0] DP_QNAN = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/dpfpm_scheduler_arb.sv
// rtl/dpfpm_scheduler_arb.sv - combinational round-robin arbiter
// Purpose: grants the first requester at or above ptr, wrapping modulo N.
// Ports:
//   req  in  N  : request vector
//   ptr  in  IW : index where the search starts
//   gnt  out N  : one-hot grant, zero when no request is present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpfpm_scheduler_mul.sv
// rtl/dpfpm_scheduler_mul.sv - combinational IEEE-754 double multiplier
// Purpose: truncating double multiply. Subnormal inputs and results flush to
//   signed zero, overflow saturates to signed infinity, NaN or inf*0 gives qNaN.
// Ports:
//   a, b  in  64 : operands
//   p     out 64 : product
module dp_mul
  import dpfpm_scheduler_pkg::*;
(
  input  logic [DP_W-1:0] a,
  input  logic [DP_W-1:0] b,
  output logic [DP_W-1:0] p
);

  logic         sp;
  logic [10:0]  ea, eb;
  logic [51:0]  fa, fb;
  logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [105:0] prod;
  logic [51:0]  frac;
  logic [12:0]  e_sum;
  logic         unused_low;

  always_comb begin
    sp     = a[63] ^ b[63];
    ea     = a[62:52];
    eb     = b[62:52];
    fa     = a[51:0];
    fb     = b[51:0];
    a_zero = (ea == 11'd0);
    b_zero = (eb == 11'd0);
    a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
    b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
    a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
    b_nan  = (eb == 11'h7FF) && (fb != 52'd0);

    prod = {53'd0, 1'b1, fa} * {53'd0, 1'b1, fb};
    // Product of two [1,2) significands lies in [1,4); bit 105 set means
    // renormalise by one place and bump the exponent.
    frac  = prod[105] ? prod[104:53] : prod[103:52];
    e_sum = {2'b00, ea} + {2'b00, eb} + {12'd0, prod[105]};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p = DP_QNAN;
    end else if (a_inf || b_inf) begin
      p = {sp, DP_INF[62:0]};
    end else if (a_zero || b_zero) begin
      p = {sp, 63'd0};
    end else if (e_sum <= 13'd1023) begin
      p = {sp, 63'd0};
    end else if (e_sum >= 13'd3070) begin
      p = {sp, DP_INF[62:0]};
    end else begin
      p = {sp, 11'(e_sum - 13'd1023), frac};
    end
  end

  // Truncation discards the low half of the significand product.
  assign unused_low = ^prod[51:0];

endmodule

// File: rtl/dpfpm_scheduler.sv
// rtl/dpfpm_scheduler.sv - round-robin scheduler sharing one multicycle FP multiplier
// Purpose: arbitrates NREQ requesters, freezes the winner's operands on the
//   multiplier for MUL_LAT cycles, then returns the product tagged with its id.
// Ports:
//   clk, rst            : clock, async active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_A, req_B        : packed operands, requester i at [64i+63:64i]
//   rsp_valid/rsp_ready : product handshake
//   rsp_id, rsp_Product : requester index and product (registered)
//   busy                : FSM not idle
//   ops_done            : wrapping count of response handshakes
module dpfpm_scheduler
  import dpfpm_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DP_W-1:0] req_A,
  input  logic [NREQ*DP_W-1:0] req_B,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [DP_W-1:0]      rsp_Product,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  localparam int             CNTW     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MUL_LAT - 1);
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, id, gnt_idx;
  logic [CNTW-1:0] cnt;
  logic [DP_W-1:0] opA, opB, mul_p, sel_a, sel_b;
  logic [NREQ-1:0] gnt;
  logic            accept, rsp_fire, calc_done;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Multiplier sees only the frozen operand registers, so its paths are
  // multicycle from opA/opB to rsp_Product.
  dp_mul u_mul (
    .a (opA),
    .b (opB),
    .p (mul_p)
  );

  // Grant encode and operand select; feeds registers only.
  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDW'(i);
        sel_a   = req_A[i*DP_W +: DP_W];
        sel_b   = req_B[i*DP_W +: DP_W];
      end
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign calc_done = (state == ST_CALC) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_CALC;
      ST_CALC: if (calc_done) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE) ? gnt : '0;
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opA         <= '0;
      opB         <= '0;
      id          <= '0;
      cnt         <= '0;
      ptr         <= '0;
      rsp_Product <= '0;
      rsp_id      <= '0;
      ops_done    <= '0;
    end else begin
      if (accept) begin
        opA <= sel_a;
        opB <= sel_b;
        id  <= gnt_idx;
        cnt <= CNT_INIT;
      end else if ((state == ST_CALC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (calc_done) begin
        rsp_Product <= mul_p;
        rsp_id      <= id;
      end
      if (rsp_fire) begin
        ptr      <= (id == ID_LAST) ? '0 : id + 1'b1;
        ops_done <= ops_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dpfpm_scheduler.sv
// tb/tb_dpfpm_scheduler.sv - self-checking bench for dpfpm_scheduler
module tb_dpfpm_scheduler;
  import dpfpm_scheduler_pkg::*;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;
  localparam int IDW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*64-1:0]   req_A, req_B;
  logic                 rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]       rsp_id;
  logic [63:0]          rsp_Product;
  logic [15:0]          ops_done;

  int tests = 0;
  int fails = 0;

  dpfpm_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_A       (req_A),
    .req_B       (req_B),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_Product (rsp_Product),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  always #5 clk = ~clk;

  // Reference product in real arithmetic; operands are kept to small
  // integers, zeros and infinities so the exact result needs no rounding.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_num();
    real r;
    r = real'($urandom_range(1, 4096));
    if ($urandom_range(0, 1) == 1) r = -r;
    return $realtobits(r);
  endfunction

  function automatic logic [63:0] gen_a();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return DP_ZERO;
    if (k == 1) return DP_INF;
    return rand_num();
  endfunction

  function automatic logic [63:0] gen_b(input logic [63:0] a);
    if (a != DP_INF && $urandom_range(0, 9) == 0) return DP_ZERO;
    return rand_num();
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    req_A     = '0;
    req_B     = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one transaction for requester who; returns latency from accept to
  // rsp_valid and the response seen, then completes the handshake.
  task automatic do_op(input int who, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] prod, output int rid, output bit ok);
    int n;
    ok   = 1'b1;
    lat  = -1;
    prod = '0;
    rid  = -1;
    req_A[who*64 +: 64] = a;
    req_B[who*64 +: 64] = b;
    req_valid[who]      = 1'b1;
    rsp_ready           = 1'b1;
    #1;
    n = 0;
    while (!req_ready[who] && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready[who]) begin
      ok        = 1'b0;
      req_valid = '0;
      return;
    end
    tick();
    req_valid[who] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!rsp_valid) ok = 1'b0;
    prod = rsp_Product;
    rid  = int'(rsp_id);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_A = '0;
    req_B = '0;
    @(negedge clk);
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests++; if (rsp_id !== '0)      begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    tests++; if (rsp_Product !== DP_ZERO) begin fails++; $display("FAIL reset_product: got %h want 0", rsp_Product); end
    tests++; if (ops_done !== 16'd0) begin fails++; $display("FAIL reset_ops_done: got %0d want 0", ops_done); end
    tests++; if (req_ready !== '0)   begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    rst = 1'b0;
    tick();
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_op();
    int lat, rid;
    logic [63:0] prod;
    bit ok;
    apply_reset();
    do_op(1, 64'h4000000000000000, 64'h4008000000000000, lat, prod, rid, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_timeout: got no handshake want handshake"); end
    tests++; if (lat != MUL_LAT + 1) begin fails++; $display("FAIL single_latency: got %0d want %0d", lat, MUL_LAT + 1); end
    tests++; if (prod !== 64'h4018000000000000) begin fails++; $display("FAIL single_product: got %h want 4018000000000000", prod); end
    tests++; if (rid != 1) begin fails++; $display("FAIL single_id: got %0d want 1", rid); end
    tests++; if (ops_done !== 16'd1) begin fails++; $display("FAIL single_ops_done: got %0d want 1", ops_done); end
  endtask

  task automatic test_special_operands();
    int lat, rid;
    logic [63:0] prod;
    bit ok;
    do_op(2, DP_ZERO, 64'h4008000000000000, lat, prod, rid, ok);
    tests++; if (!ok || prod !== DP_ZERO) begin fails++; $display("FAIL zero_product: got %h want %h", prod, DP_ZERO); end
    tests++; if (rid != 2) begin fails++; $display("FAIL zero_id: got %0d want 2", rid); end
    do_op(3, DP_INF, 64'h4000000000000000, lat, prod, rid, ok);
    tests++; if (!ok || prod !== DP_INF) begin fails++; $display("FAIL inf_product: got %h want %h", prod, DP_INF); end
    tests++; if (ops_done !== 16'd3) begin fails++; $display("FAIL special_ops_done: got %0d want 3", ops_done); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, exp_p;
    int n;
    apply_reset();
    a = rand_num();
    b = rand_num();
    exp_p = ref_mul(a, b);
    req_A[63:0] = a;
    req_B[63:0] = b;
    req_valid = 4'b0001;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin tick(); n++; end
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    tests++; if (!rsp_valid) begin fails++; $display("FAIL bp_timeout: got rsp_valid=0 want 1"); end
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_hold: got %b want 1", rsp_valid); end
      tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL bp_id_hold: got %0d want 0", rsp_id); end
      tests++; if (rsp_Product !== exp_p) begin fails++; $display("FAIL bp_product_hold: got %h want %h", rsp_Product, exp_p); end
      tests++; if (req_ready !== '0) begin fails++; $display("FAIL bp_req_ready: got %b want 0", req_ready); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b want 1", busy); end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    tests++; if (ops_done !== 16'd1) begin fails++; $display("FAIL bp_ops_done: got %0d want 1", ops_done); end
  endtask

  task automatic test_round_robin();
    logic [63:0] oa[NREQ], ob[NREQ];
    logic [63:0] exp_p;
    logic [NREQ-1:0] exp_rdy;
    int last, cyc, k, exp_id, n;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      oa[i] = rand_num();
      ob[i] = rand_num();
      req_A[i*64 +: 64] = oa[i];
      req_B[i*64 +: 64] = ob[i];
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    last = -1; cyc = 0; k = 0; exp_id = -1; exp_p = '0;
    while (k < 8 && cyc < 200) begin
      #1;
      if (req_ready != '0) begin
        exp_rdy = '0;
        exp_rdy[k % NREQ] = 1'b1;
        tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_rdy); end
        if (last >= 0) begin
          tests++; if (cyc - last != MUL_LAT + 2) begin fails++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, cyc - last, MUL_LAT + 2); end
        end
        exp_id = k % NREQ;
        exp_p  = ref_mul(oa[exp_id], ob[exp_id]);
        last = cyc;
        k++;
      end
      if (rsp_valid) begin
        tests++; if (int'(rsp_id) != exp_id) begin fails++; $display("FAIL rr_rsp_id: got %0d want %0d", rsp_id, exp_id); end
        tests++; if (rsp_Product !== exp_p) begin fails++; $display("FAIL rr_product: got %h want %h", rsp_Product, exp_p); end
      end
      tick();
      cyc++;
    end
    tests++; if (k < 8) begin fails++; $display("FAIL rr_timeout: got %0d grants want 8", k); end
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    tick();
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] a2, b2, exp_p;
    int n, lat;
    apply_reset();
    req_A[64 +: 64] = rand_num();
    req_B[64 +: 64] = rand_num();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[1] && n < 20) begin tick(); n++; end
    tick();
    req_valid = '0;
    tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    a2 = rand_num();
    b2 = rand_num();
    exp_p = ref_mul(a2, b2);
    req_A[128 +: 64] = a2;
    req_B[128 +: 64] = b2;
    req_A[192 +: 64] = rand_num();
    req_B[192 +: 64] = rand_num();
    req_valid = 4'b1100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL mid_regrant: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    tests++; if (lat != MUL_LAT + 1) begin fails++; $display("FAIL mid_latency: got %0d want %0d", lat, MUL_LAT + 1); end
    tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL mid_rsp_id: got %0d want 2", rsp_id); end
    tests++; if (rsp_Product !== exp_p) begin fails++; $display("FAIL mid_product: got %h want %h", rsp_Product, exp_p); end
    tick();
    for (int i = 0; i < 8; i++) begin
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_stale_rsp: got %b want 0", rsp_valid); end
      tick();
    end
    tests++; if (ops_done !== 16'd1) begin fails++; $display("FAIL mid_ops_done: got %0d want 1", ops_done); end
  endtask

  task automatic test_random();
    bit pending[NREQ];
    logic [63:0] oa[NREQ], ob[NREQ];
    logic [63:0] exp_p;
    logic [NREQ-1:0] exp_rdy;
    bit outstanding, seen_rsp;
    int out_id, acc_cyc, mptr, just_acc, exp_g, idx, exp_ops;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = 1'b0;
      oa[i] = '0;
      ob[i] = '0;
    end
    outstanding = 1'b0; seen_rsp = 1'b0;
    out_id = 0; acc_cyc = 0; mptr = 0; just_acc = -1; exp_ops = 0; exp_p = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (just_acc >= 0) begin
        pending[just_acc] = 1'b0;
        just_acc = -1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i] = 1'b1;
          oa[i] = gen_a();
          ob[i] = gen_b(oa[i]);
        end
        req_valid[i] = pending[i];
        req_A[i*64 +: 64] = oa[i];
        req_B[i*64 +: 64] = ob[i];
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      tests++; if (ops_done !== exp_ops[15:0]) begin fails++; $display("FAIL rnd_ops_done: got %0d want %0d", ops_done, exp_ops); end
      if (!outstanding) begin
        exp_g = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (mptr + k) % NREQ;
          if (exp_g < 0 && pending[idx]) exp_g = idx;
        end
        exp_rdy = '0;
        if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
        tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rnd_grant: got %b want %b", req_ready, exp_rdy); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rnd_idle_busy: got %b want 0", busy); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rnd_idle_rsp: got %b want 0", rsp_valid); end
        if (exp_g >= 0) begin
          outstanding = 1'b1;
          seen_rsp = 1'b0;
          out_id = exp_g;
          exp_p = ref_mul(oa[exp_g], ob[exp_g]);
          acc_cyc = cyc;
          just_acc = exp_g;
        end
      end else begin
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL rnd_busy_ready: got %b want 0", req_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rnd_busy: got %b want 1", busy); end
        if (rsp_valid) begin
          if (!seen_rsp) begin
            tests++; if (cyc - acc_cyc != MUL_LAT + 1) begin fails++; $display("FAIL rnd_latency: got %0d want %0d", cyc - acc_cyc, MUL_LAT + 1); end
            seen_rsp = 1'b1;
          end
          tests++; if (int'(rsp_id) != out_id) begin fails++; $display("FAIL rnd_rsp_id: got %0d want %0d", rsp_id, out_id); end
          tests++; if (rsp_Product !== exp_p) begin fails++; $display("FAIL rnd_product: got %h want %h", rsp_Product, exp_p); end
          if (rsp_ready) begin
            outstanding = 1'b0;
            mptr = (out_id + 1) % NREQ;
            exp_ops++;
          end
        end else begin
          tests++; if (cyc - acc_cyc > MUL_LAT) begin fails++; $display("FAIL rnd_rsp_late: got %0d cycles want <= %0d", cyc - acc_cyc, MUL_LAT); end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_A = '0;
    req_B = '0;
    test_reset();
    test_single_op();
    test_special_operands();
    test_backpressure();
    test_round_robin();
    test_reset_mid_calc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dpfpm_scheduler.md
# dpfpm_scheduler

Shares one double-precision floating-point multiplier datapath among `NREQ` requesters. Arbitrates round-robin, latches the winner's operands, holds them stable for a fixed multicycle settle window, then returns the product tagged with the requester index. Sits between the client logic and the combinational multiplier, so that multiplier can be timed as a multicycle path.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 3: settle cycles allowed for the combinational multiplier, ≥1.
- `IDW`, $clog2(NREQ): width of the requester index.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester operand valid.
- `req_ready`  out  NREQ: per-requester accept, one-hot or zero.
- `req_A`  in  NREQ*64: packed IEEE-754 double operands A; requester i at [64i+63:64i].
- `req_B`  in  NREQ*64: packed operands B, same packing as `req_A`.
- `rsp_valid`  out  1: product available.
- `rsp_ready`  in  1: consumer accepts product.
- `rsp_id`  out  IDW: index of the requester the product belongs to.
- `rsp_Product`  out  64: IEEE-754 double product.
- `busy`  out  1: state ≠ IDLE.
- `ops_done`  out  16: count of completed response handshakes, wraps.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Arbiter picks grant `g` = first i with `req_valid[i]`, searching from `ptr` upward modulo NREQ.
  - `req_ready[g]`=1 only when some `req_valid` is high; all other `req_ready` bits are 0.
  - On `req_valid[g] & req_ready[g]`: latch `req_A`/`req_B` slice g into `opA`/`opB`, latch `id`=g, load `cnt`=MUL_LAT-1, go to CALC.
- CALC:
  - `opA`/`opB` drive the multiplier and stay frozen.
  - `cnt` decrements each cycle.
  - When `cnt`==0: register the multiplier output into `rsp_Product`, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_Product` and `rsp_id` are stable until the handshake.
  - On `rsp_ready`: `ptr`=(id+1) mod NREQ, `ops_done`++, go to IDLE.
- No acceptance outside IDLE: all `req_ready`=0 in CALC and RESP.
- Fairness: a continuously requesting client waits at most NREQ-1 transactions.
- Multiplier semantics (bit-exact, including its truncation, zero and infinity handling) come entirely from the shared multiplier. The scheduler does not modify data.
- Reset values:
  - State IDLE, `ptr`=0, `cnt`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_Product`=0, `ops_done`=0, `busy`=0, `req_ready`=0.
- Reset mid-transaction: the in-flight operation is dropped with no response, and the arbiter pointer returns to 0.
- A requester dropping `req_valid` in the same cycle that `req_ready` is high is a protocol violation. Behaviour in that case is not guaranteed.

## Timing
- Accept handshake in cycle t → `rsp_valid` rises at cycle t+MUL_LAT+1.
- Earliest next accept: the cycle after the response handshake. Back-to-back throughput is therefore one op per MUL_LAT+2 cycles with `rsp_ready` tied high.
- `req_ready` is combinational from `req_valid`, `ptr` and state. No combinational path exists from `req_A`/`req_B` to any output.
- `rsp_*` outputs are registered.
- `ops_done` wraps from 0xFFFF to 0x0000.

## Structure
- Shared package constants:
  - `DP_W`=64.
  - `ST_IDLE`, `ST_CALC`, `ST_RESP` state encoding.
  - IEEE constants `DP_ZERO`=64'h0 and `DP_INF`=64'h7FF0000000000000 for benches.
- Sub-module `rr_arbiter`: inputs `req` and `ptr`, output one-hot `gnt`. Purely combinational.
- The multiplier datapath is instantiated once inside this block and fed only from `opA`/`opB`.

## Test plan
- Single op: requester 1 sends A=0x4000000000000000 (2.0), B=0x4008000000000000 (3.0), MUL_LAT=3, `rsp_ready`=1.
  - Required: `rsp_valid` 4 cycles after accept, `rsp_Product`=0x4018000000000000, `rsp_id`=1, `ops_done`=1.
- Round-robin: all 4 requesters valid continuously.
  - Required: grants in order 0,1,2,3,0; each accept is spaced MUL_LAT+2 cycles apart.
- Backpressure: `rsp_ready`=0 for 10 cycles while in RESP.
  - Required: `rsp_valid`, `rsp_id` and `rsp_Product` are held constant; all `req_ready`=0; `busy`=1.
- Zero operand: A=0x0, B=0x4008000000000000.
  - Required: `rsp_Product`=0x0.
- Infinity operand: A=0x7FF0000000000000, B=0x4000000000000000.
  - Required: `rsp_Product`=0x7FF0000000000000.
- Async reset asserted in CALC.
  - Required: state IDLE and `rsp_valid`=0 immediately. After release, requesters 2 and 3 both valid → grant goes to 2 (`ptr`=0 search), and no stale response appears.
